mfp_mac_arr: RTL
================

MFP_MAC_ARR -- requirements
Module: mfp_mac_arr

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- ArrL, 4, number of independent channels.
- In1W, 8, signed width of each In1 element.
- In2W, 8, signed width of each In2 element.
- AccW, 24, signed accumulator width; must be at least In1W+In2W-1.
- OutW, 16, signed output width; must be at most AccW.
- isFloor, 1, 1 = truncate on output rounding; 0 = round-half-up.
- Saturate, 1, 1 = saturate accumulator and output; 0 = wrap.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all registers are clocked on its rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- en, in, 1, global advance enable.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, input beat accepted when in_valid & in_ready.
- in_last, in, 1, marks the final beat of a frame.
- In1Arr, in, In1W*ArrL, channel gi at [gi*In1W +: In1W].
- In2Arr, in, In2W*ArrL, channel gi at [gi*In2W +: In2W].
- out_valid, out, 1, result valid.
- out_ready, in, 1, result consumed when out_valid & out_ready.
- OutArr, out, OutW*ArrL, channel gi at [gi*OutW +: OutW].
- ovf, out, ArrL, per-channel sticky overflow flag for the frame in OutArr.

Function
REQ-003 Advance signal: adv = en & ~(out_valid & ~out_ready).
REQ-004 in_ready SHALL equal adv whenever rst is low.
REQ-005 All pipeline registers SHALL hold their values when adv is 0.
REQ-006 Input clamp: an element equal to the most negative value -2^(W-1) SHALL be replaced by -(2^(W-1)-1) before multiplication.
REQ-007 Stage 1: on adv, register the signed product (width In1W+In2W-1), a valid bit and the last bit for each channel. The valid bit is in_valid.
REQ-008 Stage 2 accumulate: on adv with stage-1 valid:
- acc is loaded with the sign-extended product if the previous accumulated beat was last (or acc is freshly reset);
- otherwise acc = acc + product.
REQ-009 When Saturate=1, an accumulate that overflows AccW SHALL clamp to ±(2^(AccW-1)-1), sign taken from the overflow direction.
REQ-010 When Saturate=0, an accumulate that overflows AccW SHALL wrap modulo 2^AccW.
REQ-011 Either overflow case SHALL set that channel's sticky flag. Sticky flags SHALL clear on the first beat of each frame.
REQ-012 Output rounding SHALL take the top OutW bits of acc, i.e. acc[AccW-1 -: OutW]:
- isFloor=1: truncate.
- isFloor=0: add acc[AccW-OutW-1]. If this overflows, saturate to 2^(OutW-1)-1 when Saturate=1, or wrap when Saturate=0.
- OutW==AccW: pass through unchanged.
REQ-013 Stage 3: on adv, when the stage-2 beat was last, load OutArr and ovf from the rounded result and set out_valid.
REQ-014 On adv with no last beat completing, clear out_valid.
REQ-015 Latency: a last beat accepted at clock edge k SHALL produce out_valid high after edge k+2, provided adv stays 1.
REQ-016 OutArr and ovf SHALL remain stable while out_valid & ~out_ready.
REQ-017 Back-to-back frames SHALL proceed at one beat per cycle with no gap and no data loss.
REQ-018 A beat with in_valid=0 SHALL leave acc unchanged (bubble).
REQ-019 A beat with in_last=1 SHALL form a one-beat frame when the preceding beat was last.
REQ-020 Channels SHALL be fully independent; they share only the handshake.

Reset
REQ-021 While rst is high, the following SHALL be 0 immediately, without waiting for clk: all stage valid bits, acc, sticky flags, OutArr, ovf, out_valid and in_ready.
REQ-022 After rst is released, the first accepted beat SHALL start a new frame.
REQ-023 Asserting rst mid-frame SHALL discard the partial accumulation.

Verification
REQ-024 Frame scenario (ArrL=2, 8/8, AccW=OutW=16):
- Stimulus: ch0 beats 10*20, -5*4, 7*7 (last), with ch1 = 0.
- Response: OutArr ch0=229, ch1=0, ovf=00, out_valid rises 2 edges after the last beat.
REQ-025 Overflow scenario (AccW=OutW=16):
- Stimulus: 127*127 for three beats.
- Saturate=1: output 32767, ovf=1.
- Saturate=0: output -17149, ovf=1.
REQ-026 Rounding scenario (AccW=16, OutW=8):
- acc=384: isFloor=1 gives 1; isFloor=0 gives 2.
- acc=0x7FF0 with isFloor=0, Saturate=1: gives 127, not -128.
REQ-027 Clamp scenario: -128 * -128 in one beat SHALL give 16129.
REQ-028 Backpressure scenario:
- Stimulus: hold out_ready=0 for 5 cycles while two frames are streaming.
- Response: in_ready=0, OutArr stable; both results delivered in order after release.
REQ-029 Reset scenario:
- Stimulus: assert rst after 2 beats of a frame, then send a one-beat frame 3*3.
- Response: out_valid=0 during reset; next result is 9.

Source files
------------

// File: rtl/mfp_mac_arr.sv
// mfp_mac_arr: ArrL independent signed multiply-accumulate channels sharing
// one valid/ready handshake. Three pipeline stages:
//   stage 1: clamp operands, multiply, register product + valid/last
//   stage 2: per-channel accumulate (saturating or wrapping), sticky overflow
//   stage 3: round the finished accumulation to OutW bits, present result
//
// Handshake: a beat moves on a rising edge when in_valid & in_ready; a result
// leaves on a rising edge when out_valid & out_ready. The whole pipeline
// advances together on adv = en & ~(out_valid & ~out_ready). While adv is low,
// every register holds its value, so a stalled result stays stable.
module mfp_mac_arr #(
  parameter int ArrL     = 4,
  parameter int In1W     = 8,
  parameter int In2W     = 8,
  parameter int AccW     = 24,
  parameter int OutW     = 16,
  parameter bit isFloor  = 1'b1,
  parameter bit Saturate = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [In1W*ArrL-1:0]   In1Arr,
  input  logic [In2W*ArrL-1:0]   In2Arr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OutW*ArrL-1:0]   OutArr,
  output logic [ArrL-1:0]        ovf
);

  localparam int PW  = In1W + In2W - 1;
  localparam int AW1 = AccW + 1;
  localparam logic signed [AccW-1:0] ACC_POS = {1'b0, {(AccW-1){1'b1}}};
  localparam logic signed [AccW-1:0] ACC_NEG = {1'b1, {(AccW-2){1'b0}}, 1'b1};

  // Clamping the most negative operand to its symmetric neighbour keeps the
  // product inside PW bits, so the PW-wide multiply below never truncates.
  function automatic logic signed [PW-1:0] mul_clamped(
    input logic [In1W-1:0] a,
    input logic [In2W-1:0] b
  );
    logic        [In1W-1:0] ac;
    logic        [In2W-1:0] bc;
    logic signed [PW-1:0]   ax;
    logic signed [PW-1:0]   bx;
    ac = a;
    if (a == {1'b1, {(In1W-1){1'b0}}}) ac[0] = 1'b1;
    bc = b;
    if (b == {1'b1, {(In2W-1){1'b0}}}) bc[0] = 1'b1;
    ax = {{(In2W-1){ac[In1W-1]}}, ac};
    bx = {{(In1W-1){bc[In2W-1]}}, bc};
    return ax * bx;
  endfunction

  logic adv;

  // stage 1 state
  logic                 s1_valid_q;
  logic                 s1_last_q;
  logic signed [PW-1:0] s1_prod_q [ArrL];
  logic signed [PW-1:0] prod_d    [ArrL];

  // stage 2 state
  logic                   s2_valid_q;
  logic                   s2_last_q;
  logic                   first_q;
  logic signed [AccW-1:0] acc_q     [ArrL];
  logic        [ArrL-1:0] sticky_q;
  logic signed [AccW:0]   sum_d     [ArrL];
  logic signed [AccW-1:0] acc_add_d [ArrL];
  logic signed [AccW-1:0] load_d    [ArrL];
  logic        [ArrL-1:0] add_ovf_d;

  // stage 3 state
  logic                         out_valid_q;
  logic [ArrL-1:0][OutW-1:0]    out_arr_q;
  logic [ArrL-1:0]              ovf_q;
  logic [ArrL-1:0][OutW-1:0]    round_d;

  assign adv       = en & ~(out_valid_q & ~out_ready);
  assign in_ready  = adv & ~rst;
  assign out_valid = out_valid_q;
  assign OutArr    = out_arr_q;
  assign ovf       = ovf_q;

  // Per-channel clamped products of the current input beat.
  always_comb begin
    for (int gi = 0; gi < ArrL; gi++) begin
      prod_d[gi] = mul_clamped(In1Arr[gi*In1W +: In1W], In2Arr[gi*In2W +: In2W]);
    end
  end

  // Stage 1: capture products with the beat's valid and last bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int gi = 0; gi < ArrL; gi++) s1_prod_q[gi] <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_last;
      for (int gi = 0; gi < ArrL; gi++) s1_prod_q[gi] <= prod_d[gi];
    end
  end

  // Accumulate candidates: one extra bit exposes overflow as a sign-bit split.
  always_comb begin
    for (int gi = 0; gi < ArrL; gi++) begin
      sum_d[gi]     = AW1'(acc_q[gi]) + AW1'(s1_prod_q[gi]);
      add_ovf_d[gi] = sum_d[gi][AccW] ^ sum_d[gi][AccW-1];
      if (add_ovf_d[gi] && Saturate) begin
        acc_add_d[gi] = sum_d[gi][AccW] ? ACC_NEG : ACC_POS;
      end else begin
        acc_add_d[gi] = sum_d[gi][AccW-1:0];
      end
      load_d[gi] = AccW'(s1_prod_q[gi]);
    end
  end

  // Stage 2: load on the first beat of a frame, accumulate otherwise;
  // bubbles leave accumulators, sticky flags and frame position untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      first_q    <= 1'b1;
      sticky_q   <= '0;
      for (int gi = 0; gi < ArrL; gi++) acc_q[gi] <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        first_q <= s1_last_q;
        for (int gi = 0; gi < ArrL; gi++) begin
          if (first_q) begin
            acc_q[gi]    <= load_d[gi];
            sticky_q[gi] <= 1'b0;
          end else begin
            acc_q[gi]    <= acc_add_d[gi];
            sticky_q[gi] <= sticky_q[gi] | add_ovf_d[gi];
          end
        end
      end
    end
  end

  // Output rounding: keep the top OutW bits of each accumulator.
  for (genvar gi = 0; gi < ArrL; gi++) begin : g_round
    if (OutW == AccW) begin : g_pass
      assign round_d[gi] = acc_q[gi];
    end else begin : g_cut
      logic [OutW-1:0] top;
      assign top = acc_q[gi][AccW-1 -: OutW];
      if (isFloor) begin : g_floor
        assign round_d[gi] = top;
      end else begin : g_half
        localparam logic [OutW-1:0] OUT_POS = {1'b0, {(OutW-1){1'b1}}};
        logic [OutW:0] inc;
        // Round-half-up; only the positive end can overflow.
        assign inc = {top[OutW-1], top} + {{OutW{1'b0}}, acc_q[gi][AccW-OutW-1]};
        assign round_d[gi] = (inc[OutW] != inc[OutW-1]) ?
                             (Saturate ? OUT_POS : inc[OutW-1:0]) : inc[OutW-1:0];
      end
    end
  end

  // Stage 3: publish a result when a frame's last beat leaves stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_arr_q   <= '0;
      ovf_q       <= '0;
    end else if (adv) begin
      if (s2_valid_q && s2_last_q) begin
        out_valid_q <= 1'b1;
        out_arr_q   <= round_d;
        ovf_q       <= sticky_q;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
